// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and InsMem.
// The fetch stage drives the byte address; the memory answers with the
// 32-bit word for that address in the same cycle (purely combinational).
interface if_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;

    // Fetch stage side: owns the address, consumes the word.
    modport master (
        output imem_addr,
        input  imem_data
    );

    // Memory side: consumes the address, returns the word.
    modport slave (
        input  imem_addr,
        output imem_data
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the program counter, addresses the combinational instruction memory
// and captures the returned word plus PC+4 into the IF/ID register.
// Per-edge priority: reset > redirect > stall > sequential fetch.
// The PC is kept as a word index (pc[31:2]) so its low two bits are zero
// by construction and the incrementer is only 30 bits wide.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    if_stage_if.master  imem,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        misalign_err
);

    // Word-index form of the reset address; RESET_PC must be word-aligned.
    localparam logic [29:0] RESET_WORD = RESET_PC[31:2];

    logic [29:0] pc_q;
    logic [29:0] pc_d;
    logic [31:0] if_id_instr_q;
    logic [31:0] if_id_instr_d;
    logic [31:0] if_id_pc4_q;
    logic [31:0] if_id_pc4_d;
    logic        if_id_valid_q;
    logic        if_id_valid_d;
    logic        misalign_err_q;
    logic        misalign_err_d;

    // Sequential successor of the current PC (wraps modulo 2^32).
    logic [29:0] pc_seq;

    // Word index of the redirect destination, low byte-offset bits dropped.
    logic [29:0] target_word;
    logic        target_misaligned;

    // Sequential successor and redirect decode.
    always_comb begin
        pc_seq            = pc_q + 30'd1;
        target_word       = redirect_target[31:2];
        target_misaligned = (redirect_target[1:0] != 2'b00);
    end

    // Next-state selection for PC, IF/ID and the misalignment pulse.
    always_comb begin
        pc_d           = pc_q;
        if_id_instr_d  = if_id_instr_q;
        if_id_pc4_d    = if_id_pc4_q;
        if_id_valid_d  = if_id_valid_q;
        misalign_err_d = 1'b0;

        if (redirect) begin
            // Taken branch/jump: squash the word being fetched and restart.
            pc_d           = target_word;
            if_id_instr_d  = NOP_WORD;
            if_id_pc4_d    = 32'h00000000;
            if_id_valid_d  = 1'b0;
            misalign_err_d = target_misaligned;
        end else if (stall) begin
            // Hazard stall: everything holds, only the error pulse clears.
            pc_d           = pc_q;
            if_id_instr_d  = if_id_instr_q;
            if_id_pc4_d    = if_id_pc4_q;
            if_id_valid_d  = if_id_valid_q;
        end else begin
            // Sequential fetch: latch the word and its PC+4, advance PC.
            pc_d           = pc_seq;
            if_id_instr_d  = imem.imem_data;
            if_id_pc4_d    = {pc_seq, 2'b00};
            if_id_valid_d  = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q           <= RESET_WORD;
            if_id_instr_q  <= NOP_WORD;
            if_id_pc4_q    <= 32'h00000000;
            if_id_valid_q  <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            if_id_instr_q  <= if_id_instr_d;
            if_id_pc4_q    <= if_id_pc4_d;
            if_id_valid_q  <= if_id_valid_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    // Outputs come straight from registers; no path from stall/redirect.
    always_comb begin
        imem.imem_addr = {pc_q, 2'b00};
        if_id_instr    = if_id_instr_q;
        if_id_pc4      = if_id_pc4_q;
        if_id_valid    = if_id_valid_q;
        misalign_err   = misalign_err_q;
    end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed vectors with literal expectations plus a
// behavioural model that is compared against the DUT after every clock edge.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        misalign_err;

    int n_checks;
    int n_fail;

    // Instruction memory contents, indexed by address bits [9:2].
    logic [31:0] mem [256];

    if_stage_if bus ();

    if_stage #(
        .RESET_PC (32'h00000000),
        .NOP_WORD (32'h00000000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem            (bus.master),
        .if_id_instr     (if_id_instr),
        .if_id_pc4       (if_id_pc4),
        .if_id_valid     (if_id_valid),
        .misalign_err    (misalign_err)
    );

    // Combinational InsMem answering the DUT's address.
    always_comb begin
        bus.imem_data = mem[bus.imem_addr[9:2]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts it and reports a failure line.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one set of inputs at a falling edge and wait for the next one.
    task automatic applyStimulus(input logic r_n, input logic st, input logic rd, input logic [31:0] tgt);
        rst_n           = r_n;
        stall           = st;
        redirect        = rd;
        redirect_target = tgt;
        @(negedge clk);
    endtask

    // Behavioural model: full 32-bit arithmetic on byte addresses.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_mis;
    bit          m_live = 0;

    // Model update at each rising edge, then compare 1 time unit later.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
            m_mis   = 1'b0;
            m_live  = 1;
        end else if (m_live) begin
            if (redirect) begin
                m_pc    = redirect_target & 32'hFFFFFFFC;
                m_instr = 32'h0;
                m_pc4   = 32'h0;
                m_valid = 1'b0;
                m_mis   = (redirect_target % 4) != 0;
            end else if (stall) begin
                m_mis = 1'b0;
            end else begin
                m_instr = mem[(m_pc / 4) % 256];
                m_pc    = m_pc + 32'd4;
                m_pc4   = m_pc;
                m_valid = 1'b1;
                m_mis   = 1'b0;
            end
        end
        #1;
        if (m_live) begin
            checkOutput("cyc_imem_addr", bus.imem_addr, m_pc);
            checkOutput("cyc_instr", if_id_instr, m_instr);
            checkOutput("cyc_pc4", if_id_pc4, m_pc4);
            checkOutput("cyc_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
            checkOutput("cyc_misalign", {31'b0, misalign_err}, {31'b0, m_mis});
        end
    end

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] tgt;
    } vec_t;

    // Mixed stall/redirect vectors, checked by the model each cycle.
    vec_t table_v [10] = '{
        '{1'b0, 1'b0, 32'h0},
        '{1'b1, 1'b0, 32'h0},
        '{1'b0, 1'b1, 32'h00000021},
        '{1'b0, 1'b0, 32'h0},
        '{1'b1, 1'b1, 32'h00000303},
        '{1'b1, 1'b0, 32'h0},
        '{1'b0, 1'b0, 32'h0},
        '{1'b0, 1'b1, 32'h000000F8},
        '{1'b0, 1'b0, 32'h0},
        '{1'b0, 1'b0, 32'h0}
    };

    // Directed scenario with hand-computed expectations.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 ^ (i * 32'h00010101);
        mem[0]   = 32'h20080005;
        mem[1]   = 32'h20090003;
        mem[2]   = 32'h01095020;
        mem[16]  = 32'h8C0A0000;
        mem[255] = 32'hDEADBEEF;

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_addr", bus.imem_addr, 32'h0);
        checkOutput("rst_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("rst_instr", if_id_instr, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("e1_instr", if_id_instr, 32'h20080005);
        checkOutput("e1_pc4", if_id_pc4, 32'h4);
        checkOutput("e1_addr", bus.imem_addr, 32'h4);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("e2_instr", if_id_instr, 32'h20090003);
        checkOutput("e2_pc4", if_id_pc4, 32'h8);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput("stall_addr", bus.imem_addr, 32'h8);
            checkOutput("stall_instr", if_id_instr, 32'h20090003);
            checkOutput("stall_pc4", if_id_pc4, 32'h8);
            checkOutput("stall_valid", {31'b0, if_id_valid}, 32'h1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("unstall_pc4", if_id_pc4, 32'hC);
        checkOutput("unstall_instr", if_id_instr, 32'h01095020);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("pre_redir_addr", bus.imem_addr, 32'h10);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h00000040);
        checkOutput("redir_addr", bus.imem_addr, 32'h40);
        checkOutput("redir_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("redir_instr", if_id_instr, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("post_redir_instr", if_id_instr, 32'h8C0A0000);
        checkOutput("post_redir_pc4", if_id_pc4, 32'h44);
        checkOutput("post_redir_valid", {31'b0, if_id_valid}, 32'h1);

        applyStimulus(1'b1, 1'b1, 1'b1, 32'h00000080);
        checkOutput("redir_stall_addr", bus.imem_addr, 32'h80);
        checkOutput("redir_stall_valid", {31'b0, if_id_valid}, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h00000046);
        checkOutput("mis_addr", bus.imem_addr, 32'h44);
        checkOutput("mis_pulse", {31'b0, misalign_err}, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("mis_clear", {31'b0, misalign_err}, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h00000100);
        checkOutput("redir2a_valid", {31'b0, if_id_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h00000200);
        checkOutput("redir2b_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("redir2b_addr", bus.imem_addr, 32'h200);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFFFFFC);
        checkOutput("top_addr", bus.imem_addr, 32'hFFFFFFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_addr", bus.imem_addr, 32'h0);
        checkOutput("wrap_pc4", if_id_pc4, 32'h0);
        checkOutput("wrap_valid", {31'b0, if_id_valid}, 32'h1);
        checkOutput("wrap_instr", if_id_instr, 32'hDEADBEEF);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rst_stall_addr", bus.imem_addr, 32'h0);
        checkOutput("rst_stall_valid", {31'b0, if_id_valid}, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000333);
        checkOutput("rst_redir_addr", bus.imem_addr, 32'h0);
        checkOutput("rst_redir_mis", {31'b0, misalign_err}, 32'h0);

        foreach (table_v[i]) applyStimulus(1'b1, table_v[i].st, table_v[i].rd, table_v[i].tgt);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
